// File: rtl/reg_alu_sequencer.sv
// rtl/reg_alu_sequencer.sv - microprogram controller sequencing reg_bank reads, ALU launch and write-back
module reg_alu_sequencer #(
  parameter int PC_W     = 4,
  parameter int PROG_LEN = 16,
  parameter int TIMEOUT  = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  output logic [PC_W-1:0] prog_addr,
  input  logic [17:0]     prog_data,
  output logic [3:0]      seloutA,
  output logic [3:0]      seloutB,
  output logic            enrregA,
  output logic            enrregB,
  output logic            cnstA,
  output logic            cnstB,
  output logic            regwen,
  output logic [3:0]      selwreg,
  output logic [1:0]      endwreg,
  output logic [3:0]      opr,
  output logic            alu_start,
  input  logic            alu_done,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TCNT_LAST = TW'(TIMEOUT - 1);
  localparam logic [PC_W-1:0] PC_LAST   = PC_W'(PROG_LEN - 1);

  logic [2:0]      state;
  logic [PC_W-1:0] pc;
  logic [17:0]     instr;
  logic [TW-1:0]   tcnt;
  logic            err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      pc    <= '0;
      instr <= '0;
      tcnt  <= '0;
      err_q <= 1'b0;
    end else if (abort) begin
      // abort beats start in IDLE and leaves pc/err untouched everywhere
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pc    <= '0;
            err_q <= 1'b0;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          instr <= prog_data;
          state <= S_DECODE;
        end
        S_DECODE: begin
          tcnt <= '0;
          if (instr[15:12] == 4'hF) state <= S_HALT;
          else                      state <= S_EXEC;
        end
        S_EXEC: begin
          if (alu_done) begin
            state <= S_WRITE;
          end else if (tcnt == TCNT_LAST) begin
            err_q <= 1'b1;
            state <= S_HALT;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_WRITE: begin
          // the last program word halts without wrapping the pc
          if (pc == PC_LAST) begin
            state <= S_HALT;
          end else begin
            pc    <= pc + 1'b1;
            state <= S_FETCH;
          end
        end
        S_HALT:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    seloutA   = 4'h0;
    seloutB   = 4'h0;
    enrregA   = 1'b0;
    enrregB   = 1'b0;
    cnstA     = 1'b0;
    cnstB     = 1'b0;
    regwen    = 1'b0;
    selwreg   = 4'h0;
    endwreg   = 2'b00;
    opr       = 4'h0;
    alu_start = 1'b0;
    case (state)
      S_DECODE: begin
        if (instr[15:12] != 4'hF) begin
          seloutA = instr[7:4];
          seloutB = instr[3:0];
          cnstA   = instr[17];
          cnstB   = instr[16];
          enrregA = 1'b1;
          enrregB = 1'b1;
        end
      end
      S_EXEC: begin
        seloutA   = instr[7:4];
        seloutB   = instr[3:0];
        opr       = instr[15:12];
        alu_start = (tcnt == '0);
      end
      S_WRITE: begin
        // abort must kill the write in the same cycle it arrives
        regwen  = ~abort;
        selwreg = instr[11:8];
      end
      default: ;
    endcase
  end

  assign prog_addr = pc;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_HALT);
  assign err       = err_q;

endmodule

// File: tb/tb_reg_alu_sequencer.sv
// tb/tb_reg_alu_sequencer.sv - randomized self-checking bench for reg_alu_sequencer
module tb_reg_alu_sequencer;

  localparam int PL = 16;
  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  prog_addr;
  logic [17:0] prog_data;
  logic [3:0]  seloutA, seloutB, selwreg, opr;
  logic        enrregA, enrregB, cnstA, cnstB, regwen, alu_start, alu_done;
  logic [1:0]  endwreg;
  logic        busy, done, err;

  int tests = 0;
  int fails = 0;

  logic [17:0] rom [PL];
  int          alu_delay = 0;
  logic [7:0]  since = 8'd0;

  always #5 clock = ~clock;

  assign prog_data = rom[prog_addr];

  // ALU stand-in: done with launch (delay 0), n cycles later, or never (negative)
  always @(posedge clock) since <= alu_start ? 8'd1 : (since != 8'd0 ? since + 8'd1 : 8'd0);
  assign alu_done = (alu_delay == 0) ? alu_start : (alu_delay > 0 && since == 8'(alu_delay));

  reg_alu_sequencer #(.PC_W(4), .PROG_LEN(PL), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .seloutA(seloutA), .seloutB(seloutB), .enrregA(enrregA), .enrregB(enrregB),
    .cnstA(cnstA), .cnstB(cnstB), .regwen(regwen), .selwreg(selwreg), .endwreg(endwreg),
    .opr(opr), .alu_start(alu_start), .alu_done(alu_done),
    .busy(busy), .done(done), .err(err)
  );

  logic [3:0] wr_q [$];
  logic [9:0] rd_q [$];
  logic [3:0] op_q [$];
  int busy_nd, dones, starts, exec5, cnst_bad, endw_bad;

  always @(negedge clock) begin
    if (busy && !done) busy_nd++;
    if (done) dones++;
    if (regwen) begin
      wr_q.push_back(selwreg);
      if (endwreg != 2'b00) endw_bad++;
    end
    if (alu_start) begin
      starts++;
      op_q.push_back(opr);
    end
    if (enrregA) rd_q.push_back({cnstA, cnstB, seloutA, seloutB});
    if ((cnstA || cnstB) && !enrregA) cnst_bad++;
    if (busy && opr == 4'h5 && !enrregA) exec5++;
  end

  logic [3:0] exp_wr [$];
  logic [9:0] exp_rd [$];
  logic [3:0] exp_op [$];
  int exp_busy;

  task automatic clear_mon();
    wr_q.delete(); rd_q.delete(); op_q.delete();
    busy_nd = 0; dones = 0; starts = 0; exec5 = 0; cnst_bad = 0; endw_bad = 0;
  endtask

  // Reference: walk the program word by word and tally what must be seen
  task automatic build_expect();
    exp_wr.delete(); exp_rd.delete(); exp_op.delete();
    exp_busy = 0;
    for (int p = 0; p < PL; p++) begin
      exp_busy += 2;
      if (rom[p][15:12] == 4'hF) break;
      exp_rd.push_back({rom[p][17:16], rom[p][7:4], rom[p][3:0]});
      exp_op.push_back(rom[p][15:12]);
      exp_busy += alu_delay + 2;
      exp_wr.push_back(rom[p][11:8]);
    end
  endtask

  task automatic fill_halt();
    for (int i = 0; i < PL; i++) rom[i] = 18'h0F000;
  endtask

  task automatic kick();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int n;
    n = 0;
    while (n < limit) begin
      @(negedge clock);
      if (done) break;
      n++;
    end
    tests++;
    if (n >= limit) begin
      fails++;
      $display("FAIL %s: no done pulse within %0d cycles (required done=1)", name, limit);
    end
    @(posedge clock); #1;
  endtask

  task automatic check_run(input string name);
    int bad;
    bad = 0;
    if (wr_q.size() != exp_wr.size()) bad++;
    else foreach (exp_wr[i]) if (wr_q[i] !== exp_wr[i]) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL %s writes: got %0d writes, required %0d (%0d bad)", name, wr_q.size(), exp_wr.size(), bad); end
    bad = 0;
    if (rd_q.size() != exp_rd.size()) bad++;
    else foreach (exp_rd[i]) if (rd_q[i] !== exp_rd[i]) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL %s reads: got %0d reads, required %0d (%0d bad)", name, rd_q.size(), exp_rd.size(), bad); end
    bad = 0;
    if (op_q.size() != exp_op.size()) bad++;
    else foreach (exp_op[i]) if (op_q[i] !== exp_op[i]) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL %s ops: got %0d launches, required %0d (%0d bad)", name, op_q.size(), exp_op.size(), bad); end
    tests++;
    if (busy_nd != exp_busy) begin fails++; $display("FAIL %s busy_cycles: got %0d required %0d", name, busy_nd, exp_busy); end
    tests++;
    if (dones != 1 || busy !== 1'b0) begin fails++; $display("FAIL %s done/busy: dones=%0d busy=%b required 1/0", name, dones, busy); end
    tests++;
    if (cnst_bad != 0 || endw_bad != 0) begin fails++; $display("FAIL %s cnst/endwreg: cnst_bad=%0d endw_bad=%0d required 0/0", name, cnst_bad, endw_bad); end
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({busy, done, err, regwen, alu_start, enrregA, enrregB, cnstA, cnstB, prog_addr, seloutA, seloutB, selwreg, opr, endwreg} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b regwen=%b prog_addr=%h required all 0", busy, done, err, regwen, prog_addr);
    end
    @(posedge clock); #1 reset = 1'b0;
  endtask

  task automatic test_single_op();
    fill_halt();
    rom[0] = 18'h01312;
    alu_delay = 1;
    build_expect();
    clear_mon();
    kick();
    wait_done("single_op", 40);
    check_run("single_op");
    tests++;
    if (rd_q.size() != 1 || rd_q[0] !== {2'b00, 4'h1, 4'h2} || starts != 1) begin
      fails++;
      $display("FAIL single_op_detail: reads=%0d starts=%0d required 1 read of A=1,B=2 and 1 start", rd_q.size(), starts);
    end
  endtask

  task automatic test_full_program();
    for (int j = 0; j < PL; j++)
      rom[j] = {2'b00, 4'($urandom_range(0, 14)), 4'(j), 4'($urandom), 4'($urandom)};
    alu_delay = 0;
    build_expect();
    clear_mon();
    kick();
    wait_done("full_program", 200);
    check_run("full_program");
    tests++;
    if (busy_nd != 64 || wr_q.size() != 16) begin
      fails++;
      $display("FAIL full_program_count: busy=%0d writes=%0d required 64/16", busy_nd, wr_q.size());
    end
    repeat (3) @(posedge clock);
    #1;
    tests++;
    if (busy !== 1'b0 || wr_q.size() != 16) begin
      fails++;
      $display("FAIL full_program_nowrap: busy=%b writes=%0d required 0/16", busy, wr_q.size());
    end
  endtask

  task automatic test_timeout();
    fill_halt();
    rom[0] = 18'h05321;
    alu_delay = -1;
    clear_mon();
    kick();
    wait_done("timeout", 60);
    tests++;
    if (exec5 != TO) begin fails++; $display("FAIL timeout_exec_cycles: got %0d required %0d", exec5, TO); end
    tests++;
    if (err !== 1'b1 || dones != 1 || wr_q.size() != 0) begin
      fails++;
      $display("FAIL timeout_result: err=%b dones=%0d writes=%0d required 1/1/0", err, dones, wr_q.size());
    end
    // err is sticky until a new start is accepted
    repeat (2) @(posedge clock);
    #1;
    tests++;
    if (err !== 1'b1) begin fails++; $display("FAIL err_sticky: err=%b required 1", err); end
    alu_delay = 0;
    rom[0] = 18'h01312;
    kick();
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL err_clear_on_start: err=%b required 0", err); end
    wait_done("err_clear_run", 40);
  endtask

  task automatic test_reset_mid();
    fill_halt();
    rom[0] = 18'h05321;
    alu_delay = -1;
    rom[1] = 18'h0F000;
    kick();
    repeat (3) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || regwen !== 1'b0 || prog_addr !== 4'h0 || err !== 1'b0 || alu_start !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: busy=%b regwen=%b prog_addr=%h err=%b required 0/0/0/0", busy, regwen, prog_addr, err);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_release: busy=%b required 0", busy); end
  endtask

  task automatic test_abort_write();
    int n;
    fill_halt();
    rom[0] = 18'h02745;
    alu_delay = 0;
    clear_mon();
    kick();
    n = 0;
    while (n < 20) begin
      @(negedge clock);
      if (alu_start && alu_done) break;
      n++;
    end
    @(posedge clock); #1 abort = 1'b1;
    @(negedge clock);
    tests++;
    if (regwen !== 1'b0 || busy !== 1'b1 || selwreg !== 4'h7) begin
      fails++;
      $display("FAIL abort_write_cycle: regwen=%b busy=%b selwreg=%h required 0/1/7", regwen, busy, selwreg);
    end
    @(posedge clock); #1 abort = 1'b0;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL abort_to_idle: busy=%b required 0", busy); end
    repeat (4) @(posedge clock);
    #1;
    tests++;
    if (dones != 0 || wr_q.size() != 0) begin
      fails++;
      $display("FAIL abort_no_done: dones=%0d writes=%0d required 0/0", dones, wr_q.size());
    end
  endtask

  task automatic test_start_abort_idle();
    @(posedge clock); #1 start = 1'b1; abort = 1'b1;
    @(posedge clock); #1 start = 1'b0; abort = 1'b0;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL start_abort_idle: busy=%b required 0", busy); end
  endtask

  task automatic test_const_busy_start();
    fill_halt();
    rom[0] = 18'h21234;
    rom[1] = 18'h13a56;
    rom[2] = 18'h0e987;
    alu_delay = 2;
    build_expect();
    clear_mon();
    kick();
    repeat (6) @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    wait_done("const_busy_start", 60);
    check_run("const_busy_start");
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < PL; j++) begin
        rom[j] = 18'($urandom);
        if (rom[j][15:12] == 4'hF) rom[j][15:12] = 4'hE;
        if ($urandom_range(0, 7) == 0) rom[j][15:12] = 4'hF;
      end
      alu_delay = $urandom_range(0, 3);
      build_expect();
      clear_mon();
      kick();
      wait_done("random", 300);
      check_run($sformatf("random%0d", r));
    end
  endtask

  initial begin
    fill_halt();
    test_reset();
    test_single_op();
    test_full_program();
    test_timeout();
    test_reset_mid();
    test_abort_write();
    test_start_abort_idle();
    test_const_busy_start();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_alu_sequencer.md
Name: reg_alu_sequencer

Overview:
Microprogram controller that sequences the 16x64-bit complex register bank and the ALU. On start it fetches 18-bit instructions from an external program ROM, selects two source registers, launches the ALU, waits for done and writes the 64-bit result back to a destination register. It sits above reg_bank/alu in the top level and owns every reg_bank control and ALU opcode line; the datapath buses (outA/outB to ALU, result to inA) are wired outside it.

Parameters:
PC_W, 4, program counter / prog_addr width
PROG_LEN, 16, number of program words; the last valid address is PROG_LEN-1
TIMEOUT, 64, maximum cycles spent in EXEC waiting for alu_done before aborting with err

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; returns all state to IDLE
start  in  1  run request, sampled in IDLE only
abort  in  1  synchronous abort; any state -> IDLE on the next edge
prog_addr  out  PC_W  program ROM address (= pc)
prog_data  in  18  instruction: [17] cnstA, [16] cnstB, [15:12] opr, [11:8] dst, [7:4] srcA, [3:0] srcB
seloutA  out  4  reg_bank read select A
seloutB  out  4  reg_bank read select B
enrregA  out  1  reg_bank output-register enable A
enrregB  out  1  reg_bank output-register enable B
cnstA  out  1  reg_bank constant select A
cnstB  out  1  reg_bank constant select B
regwen  out  1  reg_bank write enable
selwreg  out  4  reg_bank write address
endwreg  out  2  reg_bank write mode, always 2'b00 (full 64-bit write)
opr  out  4  ALU opcode
alu_start  out  1  one-cycle ALU launch pulse
alu_done  in  1  ALU result valid
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on program completion (normal or timeout)
err  out  1  sticky timeout flag; cleared by reset or an accepted start

Behaviour:
- Reset (async): state=IDLE, pc=0, instr=0, err=0; all outputs 0, including prog_addr.
- Registered Moore FSM: IDLE, FETCH, DECODE, EXEC, WRITE, HALT. All outputs are decoded from the state and the latched instr.
- IDLE: when start=1, set pc<=0 and err<=0, then go to FETCH.
- FETCH: prog_addr=pc. The ROM is combinational; latch instr<=prog_data at the edge, then go to DECODE.
- DECODE: if instr[15:12]==4'hF (HALT opcode), go to HALT.
  - Otherwise, for this one cycle: seloutA=srcA, seloutB=srcB, cnstA/cnstB from instr, enrregA=enrregB=1. Then go to EXEC.
- EXEC: opr=instr[15:12] is held for the whole state; seloutA/seloutB stay held; enrregA/B=0.
  - alu_start=1 in the first EXEC cycle only.
  - The timeout counter starts at 0 on entry. When alu_done=1 (including in the first cycle), go to WRITE.
  - If the counter reaches TIMEOUT-1 without alu_done, set err<=1 and go to HALT; regwen is never asserted.
- WRITE: one cycle with regwen=1, selwreg=dst, endwreg=00.
  - pc<=pc+1.
  - If pc==PROG_LEN-1, go to HALT (no wrap); else go to FETCH.
- HALT: done=1 for exactly one cycle, then go to IDLE.
- Per-instruction latency: FETCH 1 + DECODE 1 + EXEC (>=1) + WRITE 1. With alu_done on the first EXEC cycle, each instruction takes 4 cycles.
- abort=1 in any non-IDLE state: go to IDLE next edge. No done pulse; err is unchanged; regwen is not issued, even if abort arrives in WRITE (regwen is suppressed combinationally).
- start while busy: ignored. start together with abort in IDLE: abort wins and the FSM stays in IDLE.
- Reset mid-operation: immediate IDLE, all outputs 0; any in-flight write is lost.
- dst==srcA/srcB is legal; a read-after-write hazard cannot occur because WRITE completes before the next FETCH.

Test Plan:
- Reset: hold reset high for 2 cycles mid-EXEC -> busy=0, regwen=0, prog_addr=0 immediately and asynchronously; err=0.
- Single op: ROM[0]=18'h0_1_3_12 (opr=1, dst=3, srcA=1, srcB=2), ROM[1]=HALT (opr=F); alu_done returned 1 cycle after alu_start -> seloutA=1, seloutB=2 with enrreg pulse in DECODE; one alu_start; regwen with selwreg=3; done pulse; busy back to 0.
- Full program: 16 non-halt instructions, dst=j, alu_done immediate -> 16 regwen pulses, selwreg 0..15 in order, exactly 64 busy cycles before HALT, done pulse, pc does not wrap.
- Timeout: TIMEOUT=8, alu_done never asserted -> 8 EXEC cycles, err=1, done pulse, no regwen. A following start clears err.
- Abort in WRITE: assert abort in the WRITE cycle -> regwen stays 0, IDLE next cycle, no done pulse.
- Constants and busy-start: instr bit[17]=1 -> cnstA=1 only during DECODE. A start pulse while busy has no effect on pc or sequence.
